// File: rtl/request_unit_if.sv
// rtl/request_unit_if.sv - control-unit/cache side signals of the request unit.
interface request_unit_if;
  logic        cu_dREN;
  logic        cu_dWEN;
  logic        cu_datomic;
  logic        cu_halt;
  logic [31:0] dmemaddr;
  logic        ihit;
  logic        dhit;
  logic        imemREN;
  logic        dmemREN;
  logic        dmemWEN;
  logic        pc_en;
  logic        halt;
  logic [31:0] sc_result;

  modport master (
    output cu_dREN, cu_dWEN, cu_datomic, cu_halt, dmemaddr, ihit, dhit,
    input  imemREN, dmemREN, dmemWEN, pc_en, halt, sc_result
  );

  modport slave (
    input  cu_dREN, cu_dWEN, cu_datomic, cu_halt, dmemaddr, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, pc_en, halt, sc_result
  );
endinterface

// File: rtl/request_unit.sv
// rtl/request_unit.sv - registered memory request sequencer with PC enable, sticky halt and LL/SC link.
// LL/SC support (link register, SCFAIL, sc_result) is built only when REQUEST_UNIT_ATOMIC_EN is defined.
module request_unit #(
  parameter int LINK_W = 32
) (
  input logic           CLK,
  input logic           nRST,
  request_unit_if.slave bus
);
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    SCFAIL = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state;
  logic   dren_q;
  logic   dwen_q;
  logic   halt_q;
  logic   pc_en_c;

  assign bus.imemREN = (state == FETCH);
  assign bus.dmemREN = dren_q;
  assign bus.dmemWEN = dwen_q;
  assign bus.halt    = halt_q;
  assign bus.pc_en   = pc_en_c;

`ifdef REQUEST_UNIT_ATOMIC_EN
  logic              link_valid;
  logic [LINK_W-1:0] link_addr;
  logic              link_hit;
  logic              sc_q;
  logic              op_ll;
  logic              op_sc;
  logic              unused_addr_bits;

  assign link_hit         = link_valid && (link_addr == bus.dmemaddr[LINK_W-1:0]);
  assign bus.sc_result    = {31'd0, sc_q};
  assign unused_addr_bits = ^bus.dmemaddr;
`else
  logic unused_atomic;

  assign bus.sc_result = 32'd1;
  assign unused_atomic = bus.cu_datomic ^ (^bus.dmemaddr);
`endif

  always_comb begin
    pc_en_c = 1'b0;
    case (state)
      FETCH:   pc_en_c = bus.ihit & ~bus.cu_halt & ~bus.cu_dREN & ~bus.cu_dWEN;
      DATA:    pc_en_c = bus.dhit;
      SCFAIL:  pc_en_c = 1'b1;
      default: pc_en_c = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= FETCH;
      dren_q <= 1'b0;
      dwen_q <= 1'b0;
      halt_q <= 1'b0;
`ifdef REQUEST_UNIT_ATOMIC_EN
      link_valid <= 1'b0;
      link_addr  <= '0;
      sc_q       <= 1'b0;
      op_ll      <= 1'b0;
      op_sc      <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (bus.ihit) begin
            if (bus.cu_halt) begin
              state  <= HALTED;
              halt_q <= 1'b1;
            end else if (bus.cu_dREN) begin
              // Load wins over a (malformed) simultaneous store decode.
              dren_q <= 1'b1;
              state  <= DATA;
`ifdef REQUEST_UNIT_ATOMIC_EN
              op_ll  <= bus.cu_datomic;
              op_sc  <= 1'b0;
`endif
            end else if (bus.cu_dWEN) begin
`ifdef REQUEST_UNIT_ATOMIC_EN
              op_ll <= 1'b0;
              op_sc <= bus.cu_datomic;
              if (!bus.cu_datomic) begin
                dwen_q <= 1'b1;
                state  <= DATA;
              end else if (link_hit) begin
                dwen_q <= 1'b1;
                sc_q   <= 1'b1;
                state  <= DATA;
              end else begin
                sc_q  <= 1'b0;
                state <= SCFAIL;
              end
`else
              dwen_q <= 1'b1;
              state  <= DATA;
`endif
            end
          end
        end
        DATA: begin
          if (bus.dhit) begin
            dren_q <= 1'b0;
            dwen_q <= 1'b0;
            state  <= FETCH;
`ifdef REQUEST_UNIT_ATOMIC_EN
            // Link changes only once the access has actually completed.
            if (op_ll) begin
              link_valid <= 1'b1;
              link_addr  <= bus.dmemaddr[LINK_W-1:0];
            end else if (op_sc) begin
              link_valid <= 1'b0;
            end else if (dwen_q && (link_addr == bus.dmemaddr[LINK_W-1:0])) begin
              link_valid <= 1'b0;
            end
`endif
          end
        end
`ifdef REQUEST_UNIT_ATOMIC_EN
        SCFAIL: begin
          link_valid <= 1'b0;
          state      <= FETCH;
        end
`endif
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - scoreboard bench for request_unit against a transaction-level model.
module tb_request_unit;
  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  request_unit_if bus ();

  request_unit #(.LINK_W(32)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

`ifdef REQUEST_UNIT_ATOMIC_EN
  localparam bit ATOMIC = 1'b1;
`else
  localparam bit ATOMIC = 1'b0;
`endif

  localparam int K_NONMEM = 0;
  localparam int K_READ   = 1;
  localparam int K_WRITE  = 2;
  localparam int K_SCFAIL = 3;

  localparam int OP_NOP  = 0;
  localparam int OP_LW   = 1;
  localparam int OP_SW   = 2;
  localparam int OP_LL   = 3;
  localparam int OP_SC   = 4;
  localparam int OP_BOTH = 5;

  typedef struct {
    int          kind;
    int          req_cycles;
    logic [31:0] sc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  bit          m_link_valid;
  logic [31:0] m_link_addr;
  logic [31:0] m_sc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_link_valid = 1'b0;
    m_link_addr  = 32'd0;
    m_sc         = ATOMIC ? 32'd0 : 32'd1;
  endtask

  task automatic clear_inputs();
    bus.ihit       = 1'b0;
    bus.dhit       = 1'b0;
    bus.cu_dREN    = 1'b0;
    bus.cu_dWEN    = 1'b0;
    bus.cu_datomic = 1'b0;
    bus.cu_halt    = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One instruction: fetch-hit cycle, then the data phase (if any), then idle gaps.
  task automatic issue(input int op, input logic [31:0] addr, input int wait_n, input bit both_atomic);
    bit   rd, wr, ll, sc;
    exp_t e;
    rd = (op == OP_LW) || (op == OP_LL) || (op == OP_BOTH);
    wr = (op == OP_SW) || (op == OP_SC) || (op == OP_BOTH);
    bus.ihit       = 1'b1;
    bus.cu_halt    = 1'b0;
    bus.cu_dREN    = rd;
    bus.cu_dWEN    = wr;
    bus.cu_datomic = (op == OP_LL) || (op == OP_SC) || ((op == OP_BOTH) && both_atomic);
    bus.dmemaddr   = addr;
    ll = rd && bus.cu_datomic && ATOMIC;
    sc = !rd && wr && bus.cu_datomic && ATOMIC;
    if (!rd && !wr) begin
      e = '{K_NONMEM, 0, m_sc};
    end else if (sc && !(m_link_valid && (m_link_addr == addr))) begin
      m_sc = 32'd0;
      m_link_valid = 1'b0;
      e = '{K_SCFAIL, 0, m_sc};
    end else begin
      if (sc) m_sc = 32'd1;
      e = '{rd ? K_READ : K_WRITE, wait_n + 1, m_sc};
      if (ll) begin
        m_link_valid = 1'b1;
        m_link_addr  = addr;
      end else if (sc || (wr && !rd && (addr == m_link_addr))) begin
        m_link_valid = 1'b0;
      end
    end
    sb.push_back(e);
    step();
    clear_inputs();
    if (e.kind == K_SCFAIL) begin
      step();
    end else if (e.kind != K_NONMEM) begin
      for (int i = 0; i < wait_n; i++) begin
        bus.ihit    = 1'($urandom_range(0, 1));
        bus.cu_dREN = 1'($urandom_range(0, 1));
        step();
      end
      bus.dhit = 1'b1;
      bus.ihit = 1'($urandom_range(0, 1));
      step();
      clear_inputs();
    end
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      bus.dhit = 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();
  endtask

  // Monitor: every pc_en marks a retired instruction; classify it and pop the scoreboard.
  int req_cnt = 0;
  always @(negedge CLK) begin
    exp_t e;
    int   kind_obs;
    if (nRST !== 1'b1) begin
      req_cnt = 0;
    end else begin
      if (bus.dmemREN || bus.dmemWEN) begin
        req_cnt++;
        check("req_exclusive", 32'(bus.dmemREN & bus.dmemWEN), 32'd0);
        check("imem_in_data", 32'(bus.imemREN), 32'd0);
      end
      if (bus.pc_en) begin
        kind_obs = bus.dmemREN ? K_READ : bus.dmemWEN ? K_WRITE : bus.imemREN ? K_NONMEM : K_SCFAIL;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pc_en: got kind %0d expected no retirement", kind_obs);
        end else begin
          e = sb.pop_front();
          check("retire_kind", 32'(kind_obs), 32'(e.kind));
          check("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
          check("sc_result", bus.sc_result, e.sc);
        end
        req_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [31:0] addr_tab [4];
    addr_tab[0] = 32'h100;
    addr_tab[1] = 32'h104;
    addr_tab[2] = 32'h200;
    addr_tab[3] = 32'h204;
    clear_inputs();
    bus.dmemaddr = 32'd0;
    nRST = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_imemREN", 32'(bus.imemREN), 32'd1);
    check("rst_dmemREN", 32'(bus.dmemREN), 32'd0);
    check("rst_dmemWEN", 32'(bus.dmemWEN), 32'd0);
    check("rst_pc_en", 32'(bus.pc_en), 32'd0);
    check("rst_halt", 32'(bus.halt), 32'd0);
    check("rst_sc_result", bus.sc_result, ATOMIC ? 32'd0 : 32'd1);
    step();
    nRST = 1'b1;
    step();

    issue(OP_NOP, 32'h0, 0, 1'b0);
    issue(OP_LW, 32'h100, 2, 1'b0);
    issue(OP_LL, 32'h200, 1, 1'b0);
    issue(OP_SC, 32'h200, 0, 1'b0);
    issue(OP_LL, 32'h200, 0, 1'b0);
    issue(OP_SW, 32'h200, 1, 1'b0);
    issue(OP_SC, 32'h200, 0, 1'b0);
    issue(OP_LL, 32'h300, 0, 1'b0);

    // Reset while a store is outstanding.
    bus.ihit     = 1'b1;
    bus.cu_dWEN  = 1'b1;
    bus.dmemaddr = 32'h400;
    step();
    clear_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    check("wen_before_rst", 32'(bus.dmemWEN), 32'd1);
    step();
    nRST = 1'b1;
    sb.delete();
    model_reset();
    @(negedge CLK);
    check("wen_after_rst", 32'(bus.dmemWEN), 32'd0);
    check("ren_after_rst", 32'(bus.dmemREN), 32'd0);
    check("imem_after_rst", 32'(bus.imemREN), 32'd1);
    step();
    issue(OP_SC, 32'h300, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      if (op > OP_BOTH) op = OP_NOP;
      issue(op, addr_tab[$urandom_range(0, 3)], int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    bus.ihit    = 1'b1;
    bus.cu_halt = 1'b1;
    @(negedge CLK);
    check("halt_cycle_pc_en", 32'(bus.pc_en), 32'd0);
    step();
    clear_inputs();
    @(negedge CLK);
    check("halt_set", 32'(bus.halt), 32'd1);
    check("halt_imemREN", 32'(bus.imemREN), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      bus.ihit    = 1'($urandom_range(0, 1));
      bus.dhit    = 1'($urandom_range(0, 1));
      bus.cu_dREN = 1'($urandom_range(0, 1));
      bus.cu_dWEN = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check("halted_pc_en", 32'(bus.pc_en), 32'd0);
      check("halted_dmemREN", 32'(bus.dmemREN), 32'd0);
      check("halted_dmemWEN", 32'(bus.dmemWEN), 32'd0);
      check("halted_halt", 32'(bus.halt), 32'd1);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
